aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_inv_round.sv | 46 ++++
 rtl/aes_decrypt_iter.sv | 103 ++++++++++
 tb/tb_aes_decrypt_iter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, inverse S-box table and GF(2^8) helpers for the iterative AES decryptor.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Row-major inverse S-box: entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse-cipher round: InvShiftRows, InvSubBytes,
// AddRoundKey and (unless is_final) InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_state_t   state,
  input  logic [127:0] round_key,
  input  logic         is_final,
  output aes_state_t   state_out
);

  logic [7:0] b_in [16];
  logic [7:0] b_sh [16];
  logic [7:0] b_ad [16];
  logic [7:0] b_mx [16];

  always_comb begin
    for (int i = 0; i < 16; i++) b_in[i] = state[127-8*i -: 8];
    // Byte i is row i%4, column i/4; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        b_sh[r+4*c] = b_in[r+4*((c-r+4)%4)];
      end
    end
    for (int i = 0; i < 16; i++) b_ad[i] = inv_sbox(b_sh[i]) ^ round_key[127-8*i -: 8];
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      b_mx[4*c+0] = gf_mul(b_ad[4*c], 8'h0e) ^ gf_mul(b_ad[4*c+1], 8'h0b)
                  ^ gf_mul(b_ad[4*c+2], 8'h0d) ^ gf_mul(b_ad[4*c+3], 8'h09);
      b_mx[4*c+1] = gf_mul(b_ad[4*c], 8'h09) ^ gf_mul(b_ad[4*c+1], 8'h0e)
                  ^ gf_mul(b_ad[4*c+2], 8'h0b) ^ gf_mul(b_ad[4*c+3], 8'h0d);
      b_mx[4*c+2] = gf_mul(b_ad[4*c], 8'h0d) ^ gf_mul(b_ad[4*c+1], 8'h09)
                  ^ gf_mul(b_ad[4*c+2], 8'h0e) ^ gf_mul(b_ad[4*c+3], 8'h0b);
      b_mx[4*c+3] = gf_mul(b_ad[4*c], 8'h0b) ^ gf_mul(b_ad[4*c+1], 8'h0d)
                  ^ gf_mul(b_ad[4*c+2], 8'h09) ^ gf_mul(b_ad[4*c+3], 8'h0e);
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) state_out[127-8*i -: 8] = is_final ? b_ad[i] : b_mx[i];
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher, one round per clk. Define AES_DEC_KEY_LATCH_EN
// to capture rk_flat at accept; otherwise rk_flat must stay stable until out_valid.
//
// state | meaning
// IDLE  | ready for a new cipher_text; in_ready=1
// RUN   | one inverse round per cycle, counter NR-1 down to 0
// DONE  | plain_text valid, held until out_ready
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [128*(KEY_BITS/32+7)-1:0]     rk_flat,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [127:0]                       cipher_text,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [127:0]                       plain_text
);

  localparam int NR  = nr_of(KEY_BITS);
  localparam int CW  = $clog2(NR);
  localparam int RKW = 128 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_decrypt_iter: KEY_BITS must be 128, 192 or 256");
  end

  fsm_state_t  fsm, fsm_nxt;
  logic [CW-1:0] cnt;
  aes_state_t  st;
  aes_state_t  round_out;
  logic [127:0] round_key;
  logic        is_final;
  logic        load;
  logic        advance;
  logic [RKW-1:0] rk_src;

  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_nxt = RUN;
      RUN:     if (cnt == '0) fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (fsm == IDLE);
    out_valid  = (fsm == DONE);
    load       = in_ready && in_valid;
    advance    = (fsm == RUN);
    // Gate the output so intermediate round states never leak out.
    plain_text = out_valid ? st : '0;
  end

`ifdef AES_DEC_KEY_LATCH_EN
  logic [RKW-1:0] key_reg;

  always_ff @(posedge clk) begin
    if (rst)       key_reg <= '0;
    else if (load) key_reg <= rk_flat;
  end

  assign rk_src = key_reg;
`else
  assign rk_src = rk_flat;
`endif

  assign round_key = rk_src[128*int'(cnt) +: 128];
  assign is_final  = (cnt == '0);

  aes_inv_round u_round (
    .state     (st),
    .round_key (round_key),
    .is_final  (is_final),
    .state_out (round_out)
  );

  // The initial AddRoundKey uses rk_flat directly: the key register is loaded on this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= '0;
      cnt <= '0;
    end else if (load) begin
      st  <= cipher_text ^ rk_flat[128*NR +: 128];
      cnt <= CW'(NR - 1);
    end else if (advance) begin
      st <= round_out;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: table of known and random vectors
// encrypted by an in-bench FIPS-197 forward cipher, plus reset/stall/stream sequences.
module tb_aes_decrypt_iter;

  localparam int KB  = 128;
  localparam int NR  = KB/32 + 6;
  localparam int NK  = KB/32;
  localparam int RKW = 128*(NR+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [RKW-1:0]   rk_flat = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [127:0]     cipher_text = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [127:0]     plain_text;

  aes_decrypt_iter #(.KEY_BITS(KB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rk_flat     (rk_flat),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cipher_text (cipher_text),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .plain_text  (plain_text)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           stall;
  } vec_t;

  vec_t         vecs [8];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk_m [15];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, x[7:0]);
      sb[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = key[255-32*i -: 32];
    for (int i = NK; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [RKW-1:0] rk_pack();
    logic [RKW-1:0] v;
    for (int r = 0; r <= NR; r++) v[128*r +: 128] = rk_m[r];
    return v;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_m[0];
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      s = o;
      if (rnd != NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          o[127-32*c -: 8] = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
          o[119-32*c -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
          o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
          o[103-32*c -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
        s = o;
      end
      s = s ^ rk_m[rnd];
    end
    return s;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input int stall,
                           input bit zero_keys, input string nm);
    int b, lat;
    logic [127:0] held;
    bit stable_ok, ready_low;
    cipher_text = ct;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    b = 0;
    while (!in_ready && b < 4*NR) begin step(); b++; end
    check({nm, " accept"}, 128'(in_ready), 128'(1));
    if (!in_ready) begin in_valid = 1'b0; return; end
    step();
    in_valid    = 1'b0;
    cipher_text = rnd128();
    if (zero_keys) rk_flat = '0;
    lat = 0;
    while (!out_valid && lat < 4*NR) begin step(); lat++; end
    check({nm, " latency"}, 128'(lat), 128'(NR));
    check({nm, " data"}, plain_text, exp);
    held = plain_text;
    stable_ok = 1'b1;
    ready_low = 1'b1;
    for (int k = 0; k < stall; k++) begin
      step();
      if (plain_text !== held || out_valid !== 1'b1) stable_ok = 1'b0;
      if (in_ready !== 1'b0) ready_low = 1'b0;
    end
    check({nm, " stall hold"}, 128'(stable_ok), 128'(1));
    check({nm, " stall in_ready low"}, 128'(ready_low), 128'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, " release in_ready"}, 128'(in_ready), 128'(1));
    check({nm, " release out_valid"}, 128'(out_valid), 128'(0));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [127:0] s_pt [3];
    logic [127:0] s_ct [3];
    int           acc_t [3];
    int           got, idx, guard;
    bit           acc;

    build_sbox();

    vecs[0].key = '0;
    for (int j = 0; j < 32; j++) vecs[0].key[255-8*j -: 8] = j[7:0];
    case (KB)
      192:     vecs[0].ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      256:     vecs[0].ct = 128'h8ea2b7ca516745bfeafc49904b496089;
      default: vecs[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    endcase
    vecs[0].pt    = 128'h00112233445566778899aabbccddeeff;
    vecs[0].stall = 0;
    for (int i = 1; i < 8; i++) begin
      vecs[i].key   = {rnd128(), rnd128()};
      vecs[i].pt    = rnd128();
      vecs[i].stall = (i == 1) ? 20 : int'($urandom_range(6, 0));
      expand(vecs[i].key);
      vecs[i].ct = enc(vecs[i].pt);
    end

    repeat (3) step();
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset plain_text", plain_text, 128'(0));
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      expand(vecs[i].key);
      rk_flat = rk_pack();
      run_block(vecs[i].ct, vecs[i].pt, vecs[i].stall, 1'b0, $sformatf("vec%0d", i));
    end

    // Abort mid-run with reset, then confirm nothing stale appears.
    expand(vecs[2].key);
    rk_flat     = rk_pack();
    cipher_text = vecs[2].ct;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort out_valid", 128'(out_valid), 128'(0));
    check("abort plain_text", plain_text, 128'(0));
    check("abort in_ready", 128'(in_ready), 128'(1));
    repeat (NR + 2) step();
    check("abort no late result", 128'(out_valid), 128'(0));
    expand(vecs[3].key);
    rk_flat = rk_pack();
    run_block(vecs[3].ct, vecs[3].pt, 0, 1'b0, "after abort");

    // Reset and in_valid on the same edge: nothing accepted.
    rst         = 1'b1;
    in_valid    = 1'b1;
    cipher_text = vecs[3].ct;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst+valid in_ready", 128'(in_ready), 128'(1));
    step();
    check("rst+valid still idle", 128'(in_ready), 128'(1));

`ifdef AES_DEC_KEY_LATCH_EN
    expand(vecs[0].key);
    rk_flat = rk_pack();
    run_block(vecs[0].ct, vecs[0].pt, 0, 1'b1, "key latch");
`endif

    // Streaming: three blocks under one key, in_valid and out_ready held high.
    expand(vecs[0].key);
    rk_flat = rk_pack();
    for (int i = 0; i < 3; i++) begin
      s_pt[i]  = rnd128();
      s_ct[i]  = enc(s_pt[i]);
      acc_t[i] = 0;
    end
    got = 0; idx = 0; guard = 0;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    cipher_text = s_ct[0];
    while (got < 3 && guard < 10*NR) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("stream data%0d", got), plain_text, s_pt[got]);
        got++;
      end
      step();
      guard++;
      if (acc) begin
        acc_t[idx] = cyc;
        idx++;
        if (idx < 3) cipher_text = s_ct[idx];
        else         in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream count", 128'(got), 128'(3));
    check("stream spacing 0-1", 128'(acc_t[1] - acc_t[0]), 128'(NR + 2));
    check("stream spacing 1-2", 128'(acc_t[2] - acc_t[1]), 128'(NR + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
